// File: rtl/q_pkg.sv
// Shared types and constants for the rotation-matrix consumer.
// Q4.12 fixed point, 3x3 row-major matrix.
package q_pkg;

  localparam int Q_SIZE = 16;
  localparam int Q_INT  = 4;
  localparam int Q_FRAC = 12;
  localparam int MAT_N  = 9;

  localparam int SAT_MAX = (1 << (Q_SIZE - 1)) - 1;
  localparam int SAT_MIN = -(1 << (Q_SIZE - 1));

  typedef logic signed [Q_SIZE-1:0] fix_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    FETCH,
    DRAIN,
    RUN
  } state_t;

endpackage

// File: rtl/fix_dot3_sat.sv
// 3-term fixed-point dot product of full-width products.
// Floors toward -inf by FRAC bits, then saturates to SIZE bits.
module fix_dot3_sat
  import q_pkg::*;
#(
  parameter int     SIZE   = Q_SIZE,
  parameter int     FRAC   = Q_FRAC,
  parameter longint SAT_HI = longint'(SAT_MAX),
  parameter longint SAT_LO = longint'(SAT_MIN)
) (
  input  logic signed [2*SIZE-1:0] p0,
  input  logic signed [2*SIZE-1:0] p1,
  input  logic signed [2*SIZE-1:0] p2,
  output logic signed [SIZE-1:0]   y
);

  localparam int AW = 2 * SIZE + 2;
  localparam logic signed [AW-1:0] HI = AW'(SAT_HI);
  localparam logic signed [AW-1:0] LO = AW'(SAT_LO);

  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shr;

  // Two guard bits keep the sum exact; >>> floors.
  always_comb begin
    sum = AW'(p0) + AW'(p1) + AW'(p2);
    shr = sum >>> FRAC;
    if (shr > HI) begin
      y = HI[SIZE-1:0];
    end else if (shr < LO) begin
      y = LO[SIZE-1:0];
    end else begin
      y = shr[SIZE-1:0];
    end
  end

endmodule

// File: rtl/q_rotate_apply.sv
// Pulls a 3x3 rotation matrix from the generator, then
// rotates a stream of 3-vectors through a 2-stage pipeline.
module q_rotate_apply
  import q_pkg::*;
#(
  parameter int SIZE = Q_SIZE,
  parameter int INT  = Q_INT,
  parameter int FRAC = Q_FRAC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic                   q_done,
  input  logic                   q_finish,
  input  logic signed [SIZE-1:0] q_data,
  output logic                   q_read,
  output logic                   mat_valid,
  output logic                   err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [SIZE-1:0] in_x,
  input  logic signed [SIZE-1:0] in_y,
  input  logic signed [SIZE-1:0] in_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [SIZE-1:0] out_x,
  output logic signed [SIZE-1:0] out_y,
  output logic signed [SIZE-1:0] out_z
);

  localparam int PW = 2 * SIZE;
  localparam int EW = INT + FRAC;
  localparam longint S_HI = (longint'(1) << (SIZE - 1)) - 1;
  localparam longint S_LO = -(longint'(1) << (SIZE - 1));
  localparam logic [3:0] K_LAST = 4'(MAT_N - 1);

  state_t state_q, state_d;
  logic [3:0] k_q, k_d;
  logic q_read_q, q_read_d;
  logic mat_valid_q, mat_valid_d;
  logic err_q, err_d;
  logic early_q, early_d;
  logic signed [EW-1:0] m_q [MAT_N];
  logic signed [EW-1:0] m_d [MAT_N];

  logic signed [SIZE-1:0] v [3];
  logic signed [PW-1:0] p_q [MAT_N];
  logic signed [PW-1:0] p_d [MAT_N];
  logic s1v_q, s1v_d;
  logic ov_q, ov_d;
  logic signed [SIZE-1:0] o_q [3];
  logic signed [SIZE-1:0] o_d [3];
  logic signed [SIZE-1:0] dot [3];

  logic out_free;
  logic s1_go;
  logic s1_room;
  logic fetch_acc;
  logic in_fire;

  assign v[0] = in_x;
  assign v[1] = in_y;
  assign v[2] = in_z;

  assign out_free  = !ov_q || out_ready;
  assign s1_go     = s1v_q && out_free;
  assign s1_room   = !s1v_q || out_free;
  assign fetch_acc = (state_q == RUN) && fetch_req
                   && !s1v_q && !ov_q;
  assign in_ready  = mat_valid_q && s1_room && !fetch_acc;
  assign in_fire   = in_valid && in_ready;

  assign q_read    = q_read_q;
  assign mat_valid = mat_valid_q;
  assign err       = err_q;
  assign out_valid = ov_q;
  assign out_x     = o_q[0];
  assign out_y     = o_q[1];
  assign out_z     = o_q[2];

  // Fetch sequencer: element n lands one cycle after read n.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    q_read_d    = q_read_q;
    mat_valid_d = mat_valid_q;
    err_d       = err_q;
    early_d     = early_q;
    m_d         = m_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          state_d     = WAIT_DONE;
          err_d       = 1'b0;
          mat_valid_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (q_done) begin
          state_d  = FETCH;
          q_read_d = 1'b1;
          k_d      = '0;
          early_d  = 1'b0;
        end
      end
      FETCH: begin
        if (k_q != 4'd0) begin
          m_d[k_q - 4'd1] = q_data;
          if (q_finish) early_d = 1'b1;
        end
        if (k_q == K_LAST) begin
          q_read_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DRAIN: begin
        m_d[K_LAST] = q_data;
        if (early_q || !q_finish) begin
          err_d       = 1'b1;
          mat_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          mat_valid_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (fetch_acc) begin
          mat_valid_d = 1'b0;
          state_d     = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 products and stage 2 output register.
  always_comb begin
    for (int i = 0; i < MAT_N; i++) begin
      p_d[i] = in_fire
             ? PW'(m_q[i]) * PW'(v[i % 3])
             : p_q[i];
    end
    s1v_d = in_fire ? 1'b1 : (s1_go ? 1'b0 : s1v_q);
    for (int r = 0; r < 3; r++) begin
      o_d[r] = s1_go ? dot[r] : o_q[r];
    end
    ov_d = s1_go ? 1'b1 : (out_ready ? 1'b0 : ov_q);
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    fix_dot3_sat #(
      .SIZE  (SIZE),
      .FRAC  (FRAC),
      .SAT_HI(S_HI),
      .SAT_LO(S_LO)
    ) u_dot (
      .p0(p_q[3*r]),
      .p1(p_q[3*r+1]),
      .p2(p_q[3*r+2]),
      .y (dot[r])
    );
  end

  // All state, async active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      q_read_q    <= 1'b0;
      mat_valid_q <= 1'b0;
      err_q       <= 1'b0;
      early_q     <= 1'b0;
      s1v_q       <= 1'b0;
      ov_q        <= 1'b0;
      for (int i = 0; i < MAT_N; i++) begin
        m_q[i] <= '0;
        p_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) o_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      q_read_q    <= q_read_d;
      mat_valid_q <= mat_valid_d;
      err_q       <= err_d;
      early_q     <= early_d;
      s1v_q       <= s1v_d;
      ov_q        <= ov_d;
      m_q         <= m_d;
      p_q         <= p_d;
      o_q         <= o_d;
    end
  end

endmodule
